// File: rtl/matab_row_sequencer_if.sv
// Control bus between the A/B row sequencer and its environment (register
// file selects, PE array load strobes and the PE compute handshake).
// The sequencer is the master: it owns the selects, strobes and PE_VALID.
interface matab_row_sequencer_if #(
    parameter int N = 16
);
    localparam int W = $clog2(N);

    // job control
    logic         start_i;
    logic         abort_i;
    logic [W-1:0] dim_a_i;
    logic [W-1:0] dim_b_i;

    // register file selects and PE array load strobes
    logic [W-1:0] seq_a_o;
    logic [W-1:0] seq_b_o;
    logic         matab_mux_o;
    logic         load_a_o;
    logic         load_b_o;

    // PE compute request handshake
    logic         pe_valid_o;
    logic         pe_ready_i;
    logic [W-1:0] out_row_o;
    logic [W-1:0] out_col_o;

    // status
    logic         busy_o;
    logic         done_o;

    modport master (
        input  start_i, abort_i, dim_a_i, dim_b_i, pe_ready_i,
        output seq_a_o, seq_b_o, matab_mux_o, load_a_o, load_b_o,
               pe_valid_o, out_row_o, out_col_o, busy_o, done_o
    );

    modport slave (
        output start_i, abort_i, dim_a_i, dim_b_i, pe_ready_i,
        input  seq_a_o, seq_b_o, matab_mux_o, load_a_o, load_b_o,
               pe_valid_o, out_row_o, out_col_o, busy_o, done_o
    );
endinterface

// File: rtl/matab_row_sequencer.sv
// Row-pair sequencer for one matrix job: for every A row it loads the row
// once, then loads each B row in turn and issues one PE compute request per
// (A, B) pair. Every output is decoded from flops only, so nothing on the
// bus combinationally depends on an input.
module matab_row_sequencer #(
    parameter int N = 16
) (
    input  logic                   clk_i,
    input  logic                   rstn_i,
    matab_row_sequencer_if.master  bus
);
    localparam int W = $clog2(N);
    localparam logic [W-1:0] ONE = W'(1);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        SEL_A = 3'd1,
        SEL_B = 3'd2,
        ISSUE = 3'd3,
        FIN   = 3'd4
    } state_t;

    state_t       state_q, state_d;
    logic [W-1:0] i_q, i_d;          // current A row
    logic [W-1:0] j_q, j_d;          // current B row
    logic [W-1:0] dim_a_q, dim_a_d;  // last A row of the job
    logic [W-1:0] dim_b_q, dim_b_d;  // last B row of the job
    logic [W-1:0] seq_a_q, seq_a_d;  // held register file A select
    logic [W-1:0] seq_b_q, seq_b_d;  // held register file B select
    logic         mux_q, mux_d;      // held register file A/B mux

    // State, counter and held-select registers with synchronous active-low reset
    always_ff @(posedge clk_i) begin
        if (!rstn_i) begin
            state_q <= IDLE;
            i_q     <= '0;
            j_q     <= '0;
            dim_a_q <= '0;
            dim_b_q <= '0;
            seq_a_q <= '0;
            seq_b_q <= '0;
            mux_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            i_q     <= i_d;
            j_q     <= j_d;
            dim_a_q <= dim_a_d;
            dim_b_q <= dim_b_d;
            seq_a_q <= seq_a_d;
            seq_b_q <= seq_b_d;
            mux_q   <= mux_d;
        end
    end

    // Next-state logic: walk j inside i, abort overrides everything but IDLE
    always_comb begin
        state_d = state_q;
        i_d     = i_q;
        j_d     = j_q;
        dim_a_d = dim_a_q;
        dim_b_d = dim_b_q;
        seq_a_d = seq_a_q;
        seq_b_d = seq_b_q;
        mux_d   = mux_q;

        case (state_q)
            IDLE: begin
                // START beats a simultaneous ABORT here: ABORT is only honoured in a job
                if (bus.start_i) begin
                    dim_a_d = bus.dim_a_i;
                    dim_b_d = bus.dim_b_i;
                    i_d     = '0;
                    j_d     = '0;
                    state_d = SEL_A;
                end
            end
            SEL_A: state_d = SEL_B;
            SEL_B: state_d = ISSUE;
            ISSUE: begin
                if (bus.pe_ready_i) begin
                    if (j_q < dim_b_q) begin
                        // A row is still latched in the PE array, only reload B
                        j_d     = j_q + ONE;
                        state_d = SEL_B;
                    end else if (i_q < dim_a_q) begin
                        j_d     = '0;
                        i_d     = i_q + ONE;
                        state_d = SEL_A;
                    end else begin
                        state_d = FIN;
                    end
                end
            end
            FIN:     state_d = IDLE;
            default: state_d = IDLE;
        endcase

        if (bus.abort_i && (state_q != IDLE)) begin
            state_d = IDLE;
            i_d     = '0;
            j_d     = '0;
        end

        // Selects change only when entering a load state, otherwise they hold
        if (state_d == SEL_A) begin
            seq_a_d = i_d;
            mux_d   = 1'b1;
        end else if (state_d == SEL_B) begin
            seq_b_d = j_d;
            mux_d   = 1'b0;
        end
    end

    // Output decode from flops only
    always_comb begin
        bus.seq_a_o     = seq_a_q;
        bus.seq_b_o     = seq_b_q;
        bus.matab_mux_o = mux_q;
        bus.load_a_o    = (state_q == SEL_A);
        bus.load_b_o    = (state_q == SEL_B);
        bus.pe_valid_o  = (state_q == ISSUE);
        bus.out_row_o   = seq_a_q;
        bus.out_col_o   = seq_b_q;
        bus.busy_o      = (state_q != IDLE);
        bus.done_o      = (state_q == FIN);
    end
endmodule

// File: tb/tb_matab_row_sequencer.sv
// Self-checking bench for matab_row_sequencer. Expected (row, col) pairs are
// queued when a job is started and popped on every observed PE handshake.
`timescale 1ns/1ps
module tb_matab_row_sequencer;
    localparam int N = 16;
    localparam int W = $clog2(N);

    logic clk;
    logic rstn;
    int   checks;
    int   errors;
    logic [2*W-1:0] exp_q[$];

    matab_row_sequencer_if #(.N(N)) sif ();

    matab_row_sequencer #(.N(N)) dut (
        .clk_i  (clk),
        .rstn_i (rstn),
        .bus    (sif)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [6*W+6-1:0] snapshot();
        return {sif.pe_valid_o, sif.out_row_o, sif.out_col_o, sif.seq_a_o, sif.seq_b_o,
                sif.matab_mux_o, sif.load_a_o, sif.load_b_o, sif.busy_o, sif.done_o,
                sif.out_row_o, sif.out_col_o};
    endfunction

    task automatic test_reset();
        logic [6*W+6-1:0] vec;
        rstn = 1'b0;
        sif.start_i = 1'b0;
        sif.abort_i = 1'b0;
        sif.dim_a_i = '0;
        sif.dim_b_i = '0;
        sif.pe_ready_i = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rstn = 1'b1;
        for (int c = 0; c < 5; c++) begin
            // ABORT while idle must have no effect
            sif.abort_i = (c == 2);
            @(negedge clk);
            vec = snapshot();
            checks++;
            if (vec !== '0) begin
                errors++;
                $display("FAIL reset_idle cycle %0d: outputs %h, required 0", c, vec);
            end
        end
        sif.abort_i = 1'b0;
        $display("test_reset done");
    endtask

    // Runs one job; optional stall of stall_len cycles on handshake number stall_pair,
    // optional extra START pulse while busy, optional ABORT together with START.
    task automatic run_job(input string name, input int da, input int db,
                           input int stall_pair, input int stall_len,
                           input int extra_start_cyc, input logic abort_w_start);
        int cyc, hs, stall_cnt, n_la, n_lb, n_done, done_cyc, d_exp, total;
        logic [2*W-1:0] exp_pair, got_pair;
        logic [6*W+6-1:0] hold, now_vec;
        logic [W-1:0] exp_sel;
        cyc = 0; hs = 0; stall_cnt = 0; n_la = 0; n_lb = 0; n_done = 0; done_cyc = -1;
        hold = '0;
        d_exp = (da + 1) * (1 + 2 * (db + 1)) + 1 + stall_len;
        total = (da + 1) * (db + 1);
        exp_q.delete();
        for (int a = 0; a <= da; a++)
            for (int b = 0; b <= db; b++)
                exp_q.push_back({W'(a), W'(b)});

        @(negedge clk);
        sif.start_i = 1'b1;
        sif.abort_i = abort_w_start;
        sif.dim_a_i = W'(da);
        sif.dim_b_i = W'(db);
        sif.pe_ready_i = 1'b1;
        @(posedge clk);
        #1;
        sif.start_i = 1'b0;
        sif.abort_i = 1'b0;
        // mid-job dimension changes must be ignored
        sif.dim_a_i = ~W'(da);
        sif.dim_b_i = ~W'(db);

        while (cyc < d_exp + 6) begin
            @(negedge clk);
            cyc++;
            sif.start_i = (cyc == extra_start_cyc);

            checks++;
            if ((int'(sif.load_a_o) + int'(sif.load_b_o) + int'(sif.pe_valid_o)) > 1) begin
                errors++;
                $display("FAIL %s exclusive cycle %0d: la=%b lb=%b pv=%b, required at most one",
                         name, cyc, sif.load_a_o, sif.load_b_o, sif.pe_valid_o);
            end
            checks++;
            if (sif.busy_o !== (cyc <= d_exp)) begin
                errors++;
                $display("FAIL %s busy cycle %0d: got %b, required %b",
                         name, cyc, sif.busy_o, (cyc <= d_exp));
            end

            if (sif.load_a_o === 1'b1) begin
                n_la++;
                exp_pair = (exp_q.size() > 0) ? exp_q[0] : '0;
                exp_sel = exp_pair[2*W-1:W];
                checks++;
                if (sif.seq_a_o !== exp_sel || sif.matab_mux_o !== 1'b1) begin
                    errors++;
                    $display("FAIL %s sel_a cycle %0d: seq_a=%0d mux=%b, required seq_a=%0d mux=1",
                             name, cyc, sif.seq_a_o, sif.matab_mux_o, exp_sel);
                end
            end
            if (sif.load_b_o === 1'b1) begin
                n_lb++;
                exp_pair = (exp_q.size() > 0) ? exp_q[0] : '0;
                exp_sel = exp_pair[W-1:0];
                checks++;
                if (sif.seq_b_o !== exp_sel || sif.matab_mux_o !== 1'b0) begin
                    errors++;
                    $display("FAIL %s sel_b cycle %0d: seq_b=%0d mux=%b, required seq_b=%0d mux=0",
                             name, cyc, sif.seq_b_o, sif.matab_mux_o, exp_sel);
                end
            end
            if (sif.done_o === 1'b1) begin
                n_done++;
                if (done_cyc < 0) done_cyc = cyc;
            end

            if (sif.pe_valid_o === 1'b1) begin
                if (hs == stall_pair && stall_cnt <= stall_len) begin
                    now_vec = snapshot();
                    if (stall_cnt == 0) begin
                        hold = now_vec;
                    end else begin
                        checks++;
                        if (now_vec !== hold) begin
                            errors++;
                            $display("FAIL %s stall_stable cycle %0d: got %h, required %h",
                                     name, cyc, now_vec, hold);
                        end
                    end
                    stall_cnt++;
                    sif.pe_ready_i = (stall_cnt > stall_len);
                end else begin
                    sif.pe_ready_i = 1'b1;
                end
                if (sif.pe_ready_i) begin
                    got_pair = {sif.out_row_o, sif.out_col_o};
                    checks++;
                    if (exp_q.size() == 0) begin
                        errors++;
                        $display("FAIL %s extra_pair: got (%0d,%0d), required no handshake",
                                 name, sif.out_row_o, sif.out_col_o);
                    end else begin
                        exp_pair = exp_q.pop_front();
                        if (got_pair !== exp_pair) begin
                            errors++;
                            $display("FAIL %s pair %0d: got (%0d,%0d), required (%0d,%0d)",
                                     name, hs, got_pair[2*W-1:W], got_pair[W-1:0],
                                     exp_pair[2*W-1:W], exp_pair[W-1:0]);
                        end
                    end
                    hs++;
                end
            end else begin
                sif.pe_ready_i = 1'($urandom_range(0, 1));
            end
        end
        sif.start_i = 1'b0;

        checks++;
        if (done_cyc != d_exp) begin
            errors++;
            $display("FAIL %s done_cycle: got %0d, required %0d", name, done_cyc, d_exp);
        end
        checks++;
        if (n_done != 1) begin
            errors++;
            $display("FAIL %s done_pulses: got %0d, required 1", name, n_done);
        end
        checks++;
        if (n_la != da + 1 || n_lb != total) begin
            errors++;
            $display("FAIL %s load_counts: got la=%0d lb=%0d, required la=%0d lb=%0d",
                     name, n_la, n_lb, da + 1, total);
        end
        checks++;
        if (hs != total || exp_q.size() != 0) begin
            errors++;
            $display("FAIL %s handshakes: got %0d (left %0d), required %0d",
                     name, hs, exp_q.size(), total);
        end
        exp_q.delete();
        $display("%s: dims (%0d,%0d) handshakes %0d done at cycle %0d", name, da, db, hs, done_cyc);
    endtask

    task automatic test_basic();
        run_job("test_basic", 1, 2, -1, 0, -1, 1'b0);
    endtask

    task automatic test_full();
        run_job("test_full", 15, 15, -1, 0, -1, 1'b0);
    endtask

    task automatic test_stall();
        // handshake index 1 is pair (0,1)
        run_job("test_stall", 1, 2, 1, 7, -1, 1'b0);
    endtask

    task automatic test_abort();
        int  cyc, hs;
        logic hit;
        logic [2*W-1:0] exp_pair, got_pair;
        cyc = 0; hs = 0; hit = 1'b0;
        exp_q.delete();
        for (int a = 0; a <= 2; a++)
            for (int b = 0; b <= 3; b++)
                exp_q.push_back({W'(a), W'(b)});
        @(negedge clk);
        sif.start_i = 1'b1;
        sif.dim_a_i = W'(2);
        sif.dim_b_i = W'(3);
        sif.pe_ready_i = 1'b1;
        @(posedge clk);
        #1;
        sif.start_i = 1'b0;
        while (!hit && cyc < 100) begin
            @(negedge clk);
            cyc++;
            sif.pe_ready_i = 1'b1;
            if (sif.pe_valid_o === 1'b1) begin
                if (hs == 2) begin
                    sif.abort_i = 1'b1;
                    hit = 1'b1;
                end else begin
                    got_pair = {sif.out_row_o, sif.out_col_o};
                    exp_pair = exp_q.pop_front();
                    checks++;
                    if (got_pair !== exp_pair) begin
                        errors++;
                        $display("FAIL test_abort pair %0d: got %h, required %h", hs, got_pair, exp_pair);
                    end
                    hs++;
                end
            end
        end
        checks++;
        if (!hit) begin
            errors++;
            $display("FAIL test_abort timeout: third request not seen in 100 cycles");
        end
        @(posedge clk);
        #1;
        sif.abort_i = 1'b0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            checks++;
            if (sif.busy_o !== 1'b0 || sif.done_o !== 1'b0 || sif.pe_valid_o !== 1'b0) begin
                errors++;
                $display("FAIL test_abort idle cycle %0d: busy=%b done=%b pv=%b, required 0 0 0",
                         c, sif.busy_o, sif.done_o, sif.pe_valid_o);
            end
        end
        exp_q.delete();
        $display("test_abort: aborted at handshake %0d", hs);
        // restart must begin again at (0,0)
        run_job("test_abort_restart", 0, 1, -1, 0, -1, 1'b0);
    endtask

    task automatic test_single();
        // extra START pulse at cycle 2 while busy must not start another job
        run_job("test_single", 0, 0, -1, 0, 2, 1'b0);
    endtask

    task automatic test_back_to_back();
        // ABORT together with START in IDLE: START wins
        run_job("test_b2b_a", 2, 1, -1, 0, -1, 1'b1);
        run_job("test_b2b_b", 1, 0, 0, 2, -1, 1'b0);
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_basic();
        test_full();
        test_stall();
        test_abort();
        test_single();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
